set_cmd_scheduler: RTL
======================

# set_cmd_scheduler

Synthesizable-style testbench scheduler that shares one bank of SET output registers between several command requesters (scenario decoders, checkers, fault-injection sequences). It arbitrates requests round-robin, applies one write at a time to the selected SET register, and optionally holds the value for a programmed number of cycles before automatically restoring the previous value. It replaces direct multi-driver access to the SET outputs in the test harness, and gives each requester a completion or error pulse.

## Interface
Parameters:
- NB_REQ, 2, number of requesters (1..8)
- SET_SIZE, 5, number of SET output registers
- SET_WIDTH, 32, width of each SET register
- HOLD_WIDTH, 16, width of the hold-cycle field
- IDX_W, derived: max(1, $clog2(SET_SIZE)), index field width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- i_req_valid  in  NB_REQ  per-requester command valid
- o_req_ready  out  NB_REQ  per-requester accept; at most one bit set
- i_req_idx  in  NB_REQ*IDX_W  packed target SET index, requester r at [r*IDX_W +: IDX_W]
- i_req_data  in  NB_REQ*SET_WIDTH  packed value to write
- i_req_hold  in  NB_REQ*HOLD_WIDTH  0 = persistent write; H>0 = pulse for H cycles then restore
- o_set  out  SET_WIDTH x SET_SIZE  unpacked array of SET registers
- o_busy  out  1  high whenever state != IDLE
- o_done  out  1  one-cycle pulse, command completed
- o_err  out  1  one-cycle pulse, command dropped (index >= SET_SIZE)
- o_grant_id  out  $clog2(NB_REQ) (min 1)  requester of the command in flight / last completed

## Operation
- FSM states: IDLE, APPLY, HOLD.
- IDLE: o_req_ready is combinational; the round-robin winner among valid requesters gets ready=1. Handshake = valid & ready. On handshake edge: latch idx, data, hold and winner id into o_grant_id; update RR pointer to the winner; go APPLY.
- Round-robin: search starts at pointer+1 modulo NB_REQ. Reset pointer = NB_REQ-1, so requester 0 has priority first.
- APPLY (one cycle, ready all 0):
  - idx >= SET_SIZE: no write, o_err pulse, go IDLE.
  - hold == 0: o_set[idx] <= data, o_done pulse, go IDLE.
  - hold > 0: save o_set[idx] into restore register, o_set[idx] <= data, counter <= hold, go HOLD.
- HOLD: counter decrements each edge. On the edge where counter == 1: o_set[idx] <= saved value, o_done pulse, go IDLE.
- One command in flight at a time. A restore never overwrites a newer write, because no other write is possible during HOLD.
- Requester inputs are sampled only at handshake. Later changes have no effect.
- All other o_set entries hold their value.
- Reset (any state, including mid-HOLD): all o_set = 0, state IDLE, o_busy/o_done/o_err = 0, o_grant_id = 0, counter = 0, RR pointer = NB_REQ-1. No restore is performed.

## Timing
- Handshake in cycle c. New value is visible on o_set from cycle c+2.
- Persistent write: o_done high in c+2 (same cycle the value appears). Next handshake possible in c+2. Peak rate is 1 command per 2 cycles.
- Error: o_err high in c+2, o_set unchanged, next handshake possible in c+2.
- Pulse of H: data visible cycles c+2..c+1+H (exactly H cycles). Restored value and o_done visible in c+2+H. Next handshake possible in c+2+H.
- o_busy high in cycles c+1 through the last cycle before the return to IDLE.
- Multiple valids in the same IDLE cycle: exactly one ready, per RR order. Losers keep valid asserted and must not drop it.
- H = max (2^HOLD_WIDTH-1): counter must not overflow, and the pulse lasts the full H cycles.

## Test plan
- Reset then single request: req0 idx=2 data=0xDEADBEEF hold=0, handshake in cycle c. Response: o_set[2]=0xDEADBEEF from c+2, o_done pulse at c+2, other entries stay 0, o_grant_id=0.
- Pulse: o_set[1]=0x5 preset, then req1 idx=1 data=0xA hold=3. Response: o_set[1]=0xA for exactly 3 cycles, then 0x5, with o_done in the first restored cycle.
- Arbitration: req0 and req1 both valid continuously with hold=0. Response: grants alternate 0,1,0,1, one handshake every 2 cycles, and ready is never set on both at once.
- Bad index with SET_SIZE=5: idx=6. Response: o_err pulse at c+2, no o_done, all o_set unchanged.
- Reset mid-HOLD: idx=0 data=0x1 hold=10, rst asserted 4 cycles after handshake. Response: o_set all 0 on the next cycle, no restore, no o_done, o_busy=0.
- Max hold with HOLD_WIDTH=4: hold=15. Response: value held exactly 15 cycles, then restored.

Source files
------------

// File: rtl/set_cmd_scheduler_if.sv
// Command bus between the requesters and the SET register scheduler.
// Packed per-requester command fields plus the shared SET bank and status pulses.
interface set_cmd_scheduler_if #(
    parameter int NB_REQ     = 2,
    parameter int SET_SIZE   = 5,
    parameter int SET_WIDTH  = 32,
    parameter int HOLD_WIDTH = 16,
    parameter int IDX_W      = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1,
    parameter int GID_W      = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
);
    logic [NB_REQ-1:0]            i_req_valid;
    logic [NB_REQ-1:0]            o_req_ready;
    logic [NB_REQ*IDX_W-1:0]      i_req_idx;
    logic [NB_REQ*SET_WIDTH-1:0]  i_req_data;
    logic [NB_REQ*HOLD_WIDTH-1:0] i_req_hold;
    logic [SET_WIDTH-1:0]         o_set [SET_SIZE];
    logic                         o_busy;
    logic                         o_done;
    logic                         o_err;
    logic [GID_W-1:0]             o_grant_id;

    modport master (
        output i_req_valid, i_req_idx, i_req_data, i_req_hold,
        input  o_req_ready, o_set, o_busy, o_done, o_err, o_grant_id
    );

    modport slave (
        input  i_req_valid, i_req_idx, i_req_data, i_req_hold,
        output o_req_ready, o_set, o_busy, o_done, o_err, o_grant_id
    );
endinterface

// File: rtl/set_cmd_scheduler.sv
// Round-robin scheduler sharing one bank of SET registers between requesters,
// with optional timed pulse writes that restore the previous value afterwards.
module set_cmd_scheduler #(
    parameter int NB_REQ     = 2,
    parameter int SET_SIZE   = 5,
    parameter int SET_WIDTH  = 32,
    parameter int HOLD_WIDTH = 16,
    parameter int IDX_W      = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1
) (
    input  logic               clk,
    input  logic               rst,
    set_cmd_scheduler_if.slave bus
);
    localparam int GID_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_HOLD} state_t;

    state_t                state_reg, state_next;
    logic [GID_W-1:0]      ptr_reg;
    logic [GID_W-1:0]      grant_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [SET_WIDTH-1:0]  data_reg;
    logic [HOLD_WIDTH-1:0] hold_reg;
    logic [HOLD_WIDTH-1:0] cnt_reg;
    logic [SET_WIDTH-1:0]  saved_reg;
    logic                  done_reg;
    logic                  err_reg;

    logic                  win_found;
    logic [GID_W-1:0]      win_id;
    logic                  idx_bad;
    logic                  hold_last;
    logic                  wr_en;
    logic [SET_WIDTH-1:0]  wr_val;
    logic [SET_WIDTH-1:0]  cur_val;
    logic [SET_WIDTH-1:0]  set_q [SET_SIZE];

    assign idx_bad   = 32'(idx_reg) >= 32'(SET_SIZE);
    assign hold_last = (cnt_reg == HOLD_WIDTH'(1));

    // Round-robin search starts just after the last winner.
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int k = 1; k <= NB_REQ; k++) begin
            cand = (int'(ptr_reg) + k) % NB_REQ;
            if (!win_found && bus.i_req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = GID_W'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (win_found) state_next = ST_APPLY;
            ST_APPLY: state_next = (idx_bad || hold_reg == '0) ? ST_IDLE : ST_HOLD;
            ST_HOLD:  if (hold_last) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NB_REQ; i++) begin
            bus.o_req_ready[i] = (state_reg == ST_IDLE) && win_found && (win_id == GID_W'(i));
        end
        bus.o_busy = (state_reg != ST_IDLE);
    end

    always_comb begin
        cur_val = '0;
        for (int i = 0; i < SET_SIZE; i++) begin
            if (idx_reg == IDX_W'(i)) cur_val = set_q[i];
        end
    end

    always_comb begin
        wr_en  = 1'b0;
        wr_val = data_reg;
        if (state_reg == ST_APPLY && !idx_bad) begin
            wr_en = 1'b1;
        end
        if (state_reg == ST_HOLD && hold_last) begin
            wr_en  = 1'b1;
            wr_val = saved_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg   <= GID_W'(NB_REQ - 1);
            grant_reg <= '0;
            idx_reg   <= '0;
            data_reg  <= '0;
            hold_reg  <= '0;
            cnt_reg   <= '0;
            saved_reg <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (win_found) begin
                        ptr_reg   <= win_id;
                        grant_reg <= win_id;
                        idx_reg   <= bus.i_req_idx[int'(win_id)*IDX_W +: IDX_W];
                        data_reg  <= bus.i_req_data[int'(win_id)*SET_WIDTH +: SET_WIDTH];
                        hold_reg  <= bus.i_req_hold[int'(win_id)*HOLD_WIDTH +: HOLD_WIDTH];
                    end
                end
                ST_APPLY: begin
                    if (idx_bad) begin
                        err_reg <= 1'b1;
                    end else if (hold_reg == '0) begin
                        done_reg <= 1'b1;
                    end else begin
                        saved_reg <= cur_val;
                        cnt_reg   <= hold_reg;
                    end
                end
                ST_HOLD: begin
                    cnt_reg <= cnt_reg - HOLD_WIDTH'(1);
                    if (hold_last) done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Each SET entry only ever loads from the single in-flight command.
    for (genvar gi = 0; gi < SET_SIZE; gi++) begin : g_set
        logic [SET_WIDTH-1:0] entry_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                entry_reg <= '0;
            end else if (wr_en && idx_reg == IDX_W'(gi)) begin
                entry_reg <= wr_val;
            end
        end

        assign set_q[gi]     = entry_reg;
        assign bus.o_set[gi] = entry_reg;
    end

    assign bus.o_done     = done_reg;
    assign bus.o_err      = err_reg;
    assign bus.o_grant_id = grant_reg;
endmodule
